// File: rtl/mult_issue_ctrl_pkg.sv
// Shared types and constants for the multiply issue/writeback path.
// Latency, funct3 encodings, tag and writeback entry layouts.
package mult_issue_ctrl_pkg;

  localparam int MULT_PPL_STAGE = 3;

  localparam logic [2:0] FUNCT3_MUL    = 3'b000;
  localparam logic [2:0] FUNCT3_MULH   = 3'b001;
  localparam logic [2:0] FUNCT3_MULHSU = 3'b010;
  localparam logic [2:0] FUNCT3_MULHU  = 3'b011;

  typedef struct packed {
    logic [4:0] rd;
    logic [2:0] funct3;
  } mul_tag_t;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_entry_t;

  typedef struct packed {
    logic a_signed;
    logic b_signed;
  } mul_sign_t;

  function automatic mul_sign_t mul_sign(
    input logic [2:0] f
  );
    mul_sign_t s;
    s = '0;
    unique case (1'b1)
      (f == FUNCT3_MULH): begin
        s.a_signed = 1'b1;
        s.b_signed = 1'b1;
      end
      (f == FUNCT3_MULHSU): begin
        s.a_signed = 1'b1;
      end
      default: s = '0;
    endcase
    return s;
  endfunction

  // Unknown funct3 codes fall back to MUL, i.e. low word.
  function automatic logic sel_high(
    input logic [2:0] f
  );
    logic h;
    h = 1'b0;
    unique case (1'b1)
      (f == FUNCT3_MULH):   h = 1'b1;
      (f == FUNCT3_MULHSU): h = 1'b1;
      (f == FUNCT3_MULHU):  h = 1'b1;
      default:              h = 1'b0;
    endcase
    return h;
  endfunction

endpackage

// File: rtl/mult_wb_fifo.sv
// In-order result buffer between the multiplier and the regfile port.
// Exposes per-entry valid/rd, oldest first, for the hazard list.
module mult_wb_fifo
  import mult_issue_ctrl_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  wb_entry_t          push_ent,
  input  logic               pop,
  output logic               head_valid,
  output wb_entry_t          head,
  output logic [CW-1:0]      count,
  output logic [DEPTH-1:0]   ent_valid,
  output logic [5*DEPTH-1:0] ent_rd
);

  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  wb_entry_t       mem [DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [CW-1:0]   cnt;
  logic            do_pop;

  function automatic logic [PW-1:0] ptr_inc(
    input logic [PW-1:0] p
  );
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  assign do_pop = pop && (cnt != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
      unique case ({push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      // Issue credits make this unreachable.
      assert (!(push && (cnt == FULL)));
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_ent;
  end

  assign head_valid = (cnt != '0);
  assign head       = mem[rd_ptr];
  assign count      = cnt;

  for (genvar k = 0; k < DEPTH; k++) begin : g_ent
    logic [PW-1:0] idx;
    assign idx = PW'((32'(rd_ptr) + 32'(k)) % 32'(DEPTH));
    assign ent_valid[k] = (CW'(k) < cnt);
    assign ent_rd[5*k +: 5] = ent_valid[k] ? mem[idx].rd : '0;
  end

endmodule

// File: rtl/mult_issue_ctrl.sv
// Issue/writeback sequencer around the fixed-latency pipelined multiplier.
// Tags ride alongside the multiplier; results drain in order to the regfile.
module mult_issue_ctrl
  import mult_issue_ctrl_pkg::*;
#(
  parameter  int WB_FIFO_DEPTH = 4,
  localparam int PEND = MULT_PPL_STAGE + WB_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_valid_i,
  output logic              issue_ready_o,
  input  logic [2:0]        issue_funct3_i,
  input  logic [31:0]       issue_rs1_i,
  input  logic [31:0]       issue_rs2_i,
  input  logic [4:0]        issue_rd_i,
  output logic              mul_valid_o,
  output logic [31:0]       mul_a_o,
  output logic [31:0]       mul_b_o,
  output logic              mul_a_signed_o,
  output logic              mul_b_signed_o,
  input  logic [63:0]       mul_res_i,
  output logic              wb_req_o,
  output logic [4:0]        wb_addr_o,
  output logic [31:0]       wb_data_o,
  input  logic              wb_gnt_i,
  output logic [5*PEND-1:0] pend_rd_o,
  output logic [PEND-1:0]   pend_busy_o
);

  localparam int CW   = $clog2(WB_FIFO_DEPTH + 1);
  localparam int LAST = MULT_PPL_STAGE - 1;
  localparam logic [CW:0] MAX_OUT = (CW + 1)'(WB_FIFO_DEPTH);

  mul_tag_t                  tag_q [MULT_PPL_STAGE];
  logic [MULT_PPL_STAGE-1:0] tag_v_q;
  logic [CW-1:0]             inflight_q;
  logic [CW-1:0]             fifo_cnt;
  logic [CW:0]               occupancy;

  logic      accept;
  logic      dispatch;
  logic      exit_v;
  mul_sign_t issue_sign;
  wb_entry_t push_ent;
  wb_entry_t head;
  logic      head_valid;
  logic      pop;

  logic [WB_FIFO_DEPTH-1:0]   fifo_valid;
  logic [5*WB_FIFO_DEPTH-1:0] fifo_rd;

  // Credits cover both in-flight and buffered ops, so a result
  // leaving the multiplier always finds a free buffer entry.
  assign occupancy     = {1'b0, inflight_q} + {1'b0, fifo_cnt};
  assign issue_ready_o = (occupancy < MAX_OUT);

  assign accept   = issue_valid_i && issue_ready_o;
  assign dispatch = accept && (issue_rd_i != '0);

  assign issue_sign     = mul_sign(issue_funct3_i);
  assign mul_valid_o    = dispatch;
  assign mul_a_o        = issue_rs1_i;
  assign mul_b_o        = issue_rs2_i;
  assign mul_a_signed_o = issue_sign.a_signed;
  assign mul_b_signed_o = issue_sign.b_signed;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag_v_q <= '0;
      for (int i = 0; i < MULT_PPL_STAGE; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      tag_v_q[0] <= dispatch;
      tag_q[0]   <= '{rd: issue_rd_i, funct3: issue_funct3_i};
      for (int i = 1; i < MULT_PPL_STAGE; i++) begin
        tag_v_q[i] <= tag_v_q[i-1];
        tag_q[i]   <= tag_q[i-1];
      end
    end
  end

  assign exit_v = tag_v_q[LAST];

  always_comb begin
    push_ent    = '0;
    push_ent.rd = tag_q[LAST].rd;
    if (sel_high(tag_q[LAST].funct3)) begin
      push_ent.data = mul_res_i[63:32];
    end else begin
      push_ent.data = mul_res_i[31:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inflight_q <= '0;
    end else begin
      unique case ({dispatch, exit_v})
        2'b10:   inflight_q <= inflight_q + 1'b1;
        2'b01:   inflight_q <= inflight_q - 1'b1;
        default: inflight_q <= inflight_q;
      endcase
    end
  end

  assign pop = head_valid && wb_gnt_i;

  mult_wb_fifo #(
    .DEPTH (WB_FIFO_DEPTH)
  ) u_wb_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (exit_v),
    .push_ent   (push_ent),
    .pop        (pop),
    .head_valid (head_valid),
    .head       (head),
    .count      (fifo_cnt),
    .ent_valid  (fifo_valid),
    .ent_rd     (fifo_rd)
  );

  assign wb_req_o  = head_valid;
  assign wb_addr_o = head.rd;
  assign wb_data_o = head.data;

  for (genvar i = 0; i < MULT_PPL_STAGE; i++) begin : g_slot
    assign pend_rd_o[5*i +: 5] = tag_v_q[i] ? tag_q[i].rd : '0;
  end

  assign pend_rd_o[5*PEND-1:5*MULT_PPL_STAGE] = fifo_rd;
  assign pend_busy_o = {fifo_valid, tag_v_q};

endmodule

// File: tb/tb_mult_issue_ctrl.sv
// Bench for mult_issue_ctrl: vector table, directed corner sequences,
// randomized traffic against a queue-based reference model.
module tb_mult_issue_ctrl;
  import mult_issue_ctrl_pkg::*;

  localparam int DEPTH = 4;
  localparam int PEND  = MULT_PPL_STAGE + DEPTH;
  localparam int LAT   = MULT_PPL_STAGE + 1;
  localparam int NV    = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              issue_valid_i = 1'b0;
  logic              issue_ready_o;
  logic [2:0]        issue_funct3_i = '0;
  logic [31:0]       issue_rs1_i = '0;
  logic [31:0]       issue_rs2_i = '0;
  logic [4:0]        issue_rd_i = '0;
  logic              mul_valid_o;
  logic [31:0]       mul_a_o;
  logic [31:0]       mul_b_o;
  logic              mul_a_signed_o;
  logic              mul_b_signed_o;
  logic [63:0]       mul_res_i;
  logic              wb_req_o;
  logic [4:0]        wb_addr_o;
  logic [31:0]       wb_data_o;
  logic              wb_gnt_i = 1'b0;
  logic [5*PEND-1:0] pend_rd_o;
  logic [PEND-1:0]   pend_busy_o;

  always #5 clk = ~clk;

  mult_issue_ctrl #(.WB_FIFO_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .issue_valid_i  (issue_valid_i),
    .issue_ready_o  (issue_ready_o),
    .issue_funct3_i (issue_funct3_i),
    .issue_rs1_i    (issue_rs1_i),
    .issue_rs2_i    (issue_rs2_i),
    .issue_rd_i     (issue_rd_i),
    .mul_valid_o    (mul_valid_o),
    .mul_a_o        (mul_a_o),
    .mul_b_o        (mul_b_o),
    .mul_a_signed_o (mul_a_signed_o),
    .mul_b_signed_o (mul_b_signed_o),
    .mul_res_i      (mul_res_i),
    .wb_req_o       (wb_req_o),
    .wb_addr_o      (wb_addr_o),
    .wb_data_o      (wb_data_o),
    .wb_gnt_i       (wb_gnt_i),
    .pend_rd_o      (pend_rd_o),
    .pend_busy_o    (pend_busy_o)
  );

  // Multiplier environment: signedness-extended product, fixed latency.
  logic [63:0] mp [MULT_PPL_STAGE];
  logic [63:0] ae, be;
  assign ae = {{32{mul_a_signed_o & mul_a_o[31]}}, mul_a_o};
  assign be = {{32{mul_b_signed_o & mul_b_o[31]}}, mul_b_o};
  always @(posedge clk) begin
    mp[0] <= mul_valid_o ? ae * be : 64'hBAD0_BAD0_BAD0_BAD0;
    for (int i = 1; i < MULT_PPL_STAGE; i++) mp[i] <= mp[i-1];
  end
  assign mul_res_i = mp[MULT_PPL_STAGE-1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int pass_cnt = 0;
  int total    = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t",
                  name, act, exp, $time);
  endtask

  function automatic logic [31:0] ref_mul(input logic [2:0] f,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    case (f)
      3'b001:  p = sa * sb;
      3'b010:  p = sa * ub;
      3'b011:  p = ua * ub;
      default: p = ua * ub;
    endcase
    return (f == 3'b001 || f == 3'b010 || f == 3'b011) ? p[63:32] : p[31:0];
  endfunction

  task automatic drive(input logic v, input logic [2:0] f,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
    issue_valid_i  = v;
    issue_funct3_i = f;
    issue_rs1_i    = a;
    issue_rs2_i    = b;
    issue_rd_i     = rd;
  endtask

  // Reference model: ops accepted but not yet written back, in order.
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    int          cyc;
  } exp_t;
  exp_t exp_q[$];
  exp_t ne;
  bit   sb_en = 1'b0;
  bit   er, eq;

  always @(negedge clk) begin
    if (sb_en) begin
      #2;
      er = (exp_q.size() < DEPTH);
      eq = (exp_q.size() > 0) && (exp_q[0].cyc + LAT <= cyc);
      chk("rnd_ready", issue_ready_o, er);
      chk("rnd_mul_valid", mul_valid_o,
          issue_valid_i && er && (issue_rd_i != 0));
      chk("rnd_wb_req", wb_req_o, eq);
      if (eq) begin
        chk("rnd_wb_addr", wb_addr_o, exp_q[0].rd);
        chk("rnd_wb_data", wb_data_o, exp_q[0].data);
      end
      chk("rnd_pend_count", $countones(pend_busy_o), exp_q.size());
      if (eq && wb_gnt_i) void'(exp_q.pop_front());
      if (issue_valid_i && er && (issue_rd_i != 0)) begin
        ne.rd   = issue_rd_i;
        ne.data = ref_mul(issue_funct3_i, issue_rs1_i, issue_rs2_i);
        ne.cyc  = cyc;
        exp_q.push_back(ne);
      end
    end
  end

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
  } vec_t;
  vec_t vt [NV];

  logic [5*PEND-1:0] e_rd;

  initial begin
    vt[0] = '{3'b000, 32'd7,          32'd6,          5'd5,  32'd42};
    vt[1] = '{3'b001, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd6,  32'h0000_0000};
    vt[2] = '{3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd7,  32'hFFFF_FFFE};
    vt[3] = '{3'b010, 32'hFFFF_FFFF,  32'd2,          5'd8,  32'hFFFF_FFFF};
    vt[4] = '{3'b000, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd9,  32'h0000_0001};
    vt[5] = '{3'b001, 32'h8000_0000,  32'h8000_0000,  5'd10, 32'h4000_0000};
    vt[6] = '{3'b101, 32'd3,          32'd5,          5'd31, 32'd15};
    vt[7] = '{3'b011, 32'h8000_0000,  32'd2,          5'd1,  32'h0000_0001};

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_wb_req", wb_req_o, 0);
    chk("rst_busy", pend_busy_o, 0);
    chk("rst_mul_valid", mul_valid_o, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_ready", issue_ready_o, 1);

    // Single ops, grant always on: latency and result select
    wb_gnt_i = 1'b1;
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(1'b1, vt[i].f, vt[i].a, vt[i].b, vt[i].rd);
      #1;
      chk("vec_mul_valid", mul_valid_o, 1);
      for (int k = 1; k <= LAT; k++) begin
        @(negedge clk);
        issue_valid_i = 1'b0;
        #1;
        if (k < LAT) begin
          chk("vec_early_req", wb_req_o, 0);
        end else begin
          chk("vec_req", wb_req_o, 1);
          chk("vec_addr", wb_addr_o, vt[i].rd);
          chk("vec_data", wb_data_o, vt[i].exp);
        end
      end
      @(negedge clk);
      #1;
      chk("vec_req_clear", wb_req_o, 0);
    end

    // Four back-to-back ops with the write port blocked
    @(negedge clk);
    wb_gnt_i = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      if (i > 1) @(negedge clk);
      drive(1'b1, 3'b000, 32'(i), 32'd10, 5'(i));
      #1;
      chk("bb_ready", issue_ready_o, 1);
    end
    @(negedge clk);
    drive(1'b1, 3'b000, 32'd1, 32'd1, 5'd9);
    #1;
    chk("bb_full", issue_ready_o, 0);
    chk("bb_no_dispatch", mul_valid_o, 0);
    e_rd = '0;
    e_rd[4:0]   = 5'd4;
    e_rd[9:5]   = 5'd3;
    e_rd[14:10] = 5'd2;
    e_rd[19:15] = 5'd1;
    chk("bb_pend_rd_mix", pend_rd_o, e_rd);
    chk("bb_pend_busy_mix", pend_busy_o, 7'b0001111);
    @(negedge clk);
    issue_valid_i = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    e_rd = '0;
    e_rd[19:15] = 5'd1;
    e_rd[24:20] = 5'd2;
    e_rd[29:25] = 5'd3;
    e_rd[34:30] = 5'd4;
    chk("bb_pend_rd_fifo", pend_rd_o, e_rd);
    chk("bb_pend_busy_fifo", pend_busy_o, 7'b1111000);
    chk("bb_still_full", issue_ready_o, 0);
    wb_gnt_i = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      #1;
      chk("bb_wb_req", wb_req_o, 1);
      chk("bb_wb_addr", wb_addr_o, 5'(i));
      chk("bb_wb_data", wb_data_o, 32'(i * 10));
      @(negedge clk);
    end
    #1;
    chk("bb_drained", wb_req_o, 0);
    chk("bb_ready_again", issue_ready_o, 1);

    // rd == 0: handshake only
    @(negedge clk);
    drive(1'b1, 3'b000, 32'd3, 32'd3, 5'd0);
    #1;
    chk("x0_ready", issue_ready_o, 1);
    chk("x0_mul_valid", mul_valid_o, 0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      issue_valid_i = 1'b0;
      #1;
      chk("x0_busy", pend_busy_o, 0);
      chk("x0_wb_req", wb_req_o, 0);
    end

    // Grant toggling while results stream, then random traffic
    @(posedge clk);
    sb_en = 1'b1;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      wb_gnt_i = (c % 2 == 0);
      if (c < 4) drive(1'b1, 3'b011, $urandom, $urandom, 5'(11 + c));
      else issue_valid_i = 1'b0;
    end
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      drive(($urandom % 3) != 0, 3'($urandom),
            ($urandom % 4 == 0) ? 32'hFFFF_FFFF : $urandom,
            ($urandom % 5 == 0) ? 32'h8000_0000 : $urandom,
            5'($urandom));
      wb_gnt_i = ($urandom % 4) != 0;
    end
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      issue_valid_i = 1'b0;
      wb_gnt_i = 1'b1;
    end
    @(posedge clk);
    sb_en = 1'b0;
    chk("rnd_drain_empty", exp_q.size(), 0);

    // Reset in the middle of two in-flight ops
    @(negedge clk);
    wb_gnt_i = 1'b0;
    drive(1'b1, 3'b000, 32'd2, 32'd3, 5'd7);
    @(negedge clk);
    drive(1'b1, 3'b000, 32'd4, 32'd5, 5'd8);
    @(negedge clk);
    issue_valid_i = 1'b0;
    @(negedge clk);
    #1;
    chk("mrst_pre_busy", $countones(pend_busy_o), 2);
    rst = 1'b0;
    #1;
    chk("mrst_busy", pend_busy_o, 0);
    chk("mrst_pend_rd", pend_rd_o, 0);
    chk("mrst_wb_req", wb_req_o, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    wb_gnt_i = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      #1;
      chk("mrst_after_req", wb_req_o, 0);
      chk("mrst_after_ready", issue_ready_o, 1);
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
